// File: rtl/alu_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_serial_pkg
// Purpose : Shared types for the nibble-serial ALU: operation encoding,
//           sequencer state and BCD adjust constants.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package alu_serial_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_CP  = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOT = 4'd6,
    OP_RRC = 4'd7,
    OP_RLC = 4'd8
  } alu_op;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } alu_serial_state;

  localparam int BCD_RADIX   = 10;
  localparam int BCD_SUB_ADJ = 6;

endpackage
`default_nettype wire

// File: rtl/alu_nibble.sv
`default_nettype none
// ============================================================================
// Module  : alu_nibble
// Purpose : Combinational 4-bit ALU slice. The carry input is the chained
//           carry/borrow for arithmetic, and the bit shifted in for rotates.
// Ports   : op      - operation
//           a_i     - operand A nibble
//           b_i     - operand B nibble
//           carry_i - incoming carry / borrow / shift-in bit
//           decimal - BCD adjust enable for ADD/SUB/CP
//           out_i   - result nibble
//           carry_o - outgoing carry / borrow / shift-out bit
// Rev     : 1.0  initial release
// ============================================================================
module alu_nibble
  import alu_serial_pkg::*;
(
  input  alu_op      op,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  input  logic       decimal,
  output logic [3:0] out_i,
  output logic       carry_o
);

  logic [4:0] sum;
  logic [4:0] diff;
  logic [4:0] sum_adj;
  logic [4:0] diff_adj;

  always_comb begin
    sum      = {1'b0, a_i} + {1'b0, b_i} + {4'b0, carry_i};
    diff     = {1'b0, a_i} - {1'b0, b_i} - {4'b0, carry_i};
    sum_adj  = sum - 5'(BCD_RADIX);
    diff_adj = diff - 5'(BCD_SUB_ADJ);
    out_i    = 4'h0;
    carry_o  = carry_i;
    case (op)
      OP_ADD: begin
        if (decimal && (sum >= 5'(BCD_RADIX))) begin
          out_i   = sum_adj[3:0];
          carry_o = 1'b1;
        end else begin
          {carry_o, out_i} = sum;
        end
      end
      OP_SUB, OP_CP: begin
        // A negative nibble difference borrows and is folded into 0..9 by -6.
        if (decimal && diff[4]) begin
          out_i   = diff_adj[3:0];
          carry_o = 1'b1;
        end else begin
          {carry_o, out_i} = diff;
        end
      end
      OP_AND: out_i = a_i & b_i;
      OP_OR:  out_i = a_i | b_i;
      OP_XOR: out_i = a_i ^ b_i;
      OP_NOT: out_i = ~a_i;
      OP_RRC: begin
        out_i   = {carry_i, a_i[3:1]};
        carry_o = a_i[0];
      end
      OP_RLC: begin
        out_i   = {a_i[2:0], carry_i};
        carry_o = a_i[3];
      end
      default: begin
        out_i   = 4'h0;
        carry_o = carry_i;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_serial.sv
`default_nettype none
// ============================================================================
// Module  : alu_serial
// Purpose : Multi-nibble ALU that processes one nibble per clock through a
//           single time-multiplexed alu_nibble slice, with a start/done
//           handshake.
// Ports   : clk, reset (async, active-high)
//           start, op, use_carry, decimal, carry_in, a, b  - request
//           ready     - idle, start will be accepted
//           done      - one-cycle pulse, outputs just updated
//           result, carry_out, zero_out - held results
// Rev     : 1.0  initial release
// ============================================================================
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  alu_op                op,
  input  logic                 use_carry,
  input  logic                 decimal,
  input  logic                 carry_in,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 ready,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 carry_out,
  output logic                 zero_out
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  alu_serial_state state_q, state_d;
  alu_op           op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [W-1:0]    result_q, result_d;
  logic            dec_q, dec_d, carry_q, carry_d;
  logic            carry_out_q, carry_out_d, zero_out_q, zero_out_d;
  logic            done_q, done_d, ready_q, ready_d;

  logic [CW-1:0]   nib_idx;
  logic [3:0]      nib_out;
  logic            nib_carry;
  logic            last_nib;
  logic            seed;

  // RRC walks from the most significant nibble down; everything else LSN first.
  assign nib_idx  = (op_q == OP_RRC) ? (CW'(NIBBLES - 1) - cnt_q) : cnt_q;
  assign last_nib = (cnt_q == CW'(NIBBLES - 1));

  alu_nibble u_nibble (
    .op      (op_q),
    .a_i     (a_q[nib_idx*4 +: 4]),
    .b_i     (b_q[nib_idx*4 +: 4]),
    .carry_i (carry_q),
    .decimal (dec_q),
    .out_i   (nib_out),
    .carry_o (nib_carry)
  );

  // Chain seed: CP ignores the incoming carry, ADD/SUB gate it with
  // use_carry, logic ops and rotates carry carry_in straight through.
  always_comb begin
    case (op)
      OP_ADD, OP_SUB: seed = use_carry & carry_in;
      OP_CP:          seed = 1'b0;
      default:        seed = carry_in;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    dec_d       = dec_q;
    carry_d     = carry_q;
    result_d    = result_q;
    carry_out_d = carry_out_q;
    zero_out_d  = zero_out_q;
    ready_d     = ready_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          op_d    = op;
          a_d     = a;
          b_d     = b;
          dec_d   = decimal;
          carry_d = seed;
          cnt_d   = '0;
          acc_d   = '0;
          ready_d = 1'b0;
        end
      end
      RUN: begin
        acc_d[nib_idx*4 +: 4] = nib_out;
        carry_d               = nib_carry;
        cnt_d                 = cnt_q + 1'b1;
        if (last_nib) begin
          state_d     = IDLE;
          ready_d     = 1'b1;
          done_d      = 1'b1;
          result_d    = acc_d;
          carry_out_d = nib_carry;
          zero_out_d  = (acc_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      dec_q       <= 1'b0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_out_q  <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      dec_q       <= dec_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      carry_out_q <= carry_out_d;
      zero_out_q  <= zero_out_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = carry_out_q;
  assign zero_out  = zero_out_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_serial
// Purpose : Self-checking bench for alu_serial (NIBBLES=2): directed cases
//           plus randomized operations against a word-level reference model.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_alu_serial;
  import alu_serial_pkg::*;

  localparam int N = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  alu_op        op;
  logic         use_carry, decimal, carry_in;
  logic [W-1:0] a, b;
  logic         ready, done, carry_out, zero_out;
  logic [W-1:0] result;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] prev_res;
  logic         prev_c, prev_z;

  alu_serial #(.NIBBLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .use_carry (use_carry),
    .decimal   (decimal),
    .carry_in  (carry_in),
    .a         (a),
    .b         (b),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .zero_out  (zero_out)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Returns {carry, result}. Binary arithmetic is done on whole words; the
  // decimal variants apply the per-digit adjust rule digit by digit.
  function automatic logic [W:0] model(input alu_op o, input logic [W-1:0] aa,
                                       input logic [W-1:0] bb, input logic uc,
                                       input logic dec, input logic ci);
    logic [W:0]   r;
    logic [W-1:0] res;
    logic         c;
    int           t;
    r = '0;
    case (o)
      OP_ADD: begin
        c = uc & ci;
        if (!dec) r = {1'b0, aa} + {1'b0, bb} + {{W{1'b0}}, c};
        else begin
          res = '0;
          for (int i = 0; i < N; i++) begin
            t = int'(aa[4*i +: 4]) + int'(bb[4*i +: 4]) + int'(c);
            if (t >= 10) begin t = t - 10; c = 1'b1; end
            else c = (t >= 16);
            res[4*i +: 4] = 4'(t % 16);
          end
          r = {c, res};
        end
      end
      OP_SUB, OP_CP: begin
        c = (o == OP_SUB) ? (uc & ci) : 1'b0;
        if (!dec) begin
          r[W-1:0] = aa - bb - {{(W-1){1'b0}}, c};
          r[W]     = (int'(aa) < int'(bb) + int'(c));
        end else begin
          res = '0;
          for (int i = 0; i < N; i++) begin
            t = int'(aa[4*i +: 4]) - int'(bb[4*i +: 4]) - int'(c);
            c = (t < 0);
            if (t < 0) t = t + 32 - 6;
            res[4*i +: 4] = 4'(t % 16);
          end
          r = {c, res};
        end
      end
      OP_AND: r = {ci, aa & bb};
      OP_OR:  r = {ci, aa | bb};
      OP_XOR: r = {ci, aa ^ bb};
      OP_NOT: r = {ci, ~aa};
      OP_RRC: r = {aa[0], ci, aa[W-1:1]};
      OP_RLC: r = {aa[W-1], aa[W-2:0], ci};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Launches one operation and checks it to completion. With b2b set the
  // caller is already inside a done cycle and start is raised immediately.
  task automatic run_op(input alu_op o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic uc, input logic dec, input logic ci, input bit b2b);
    logic [W:0] exp;
    int         cyc;
    bit         got_done;
    if (!b2b) @(negedge clk);
    op = o; a = aa; b = bb; use_carry = uc; decimal = dec; carry_in = ci;
    start = 1'b1;
    exp = model(o, aa, bb, uc, dec, ci);
    @(posedge clk); #1;
    check_eq("ready_busy", ready, 0);
    cyc = 0;
    got_done = 0;
    while (!got_done && cyc < N + 4) begin
      // Scrambled inputs and spurious starts while busy must be ignored.
      start     = 1'($urandom_range(0, 1));
      op        = alu_op'($urandom_range(0, 8));
      a         = W'($urandom);
      b         = W'($urandom);
      use_carry = 1'($urandom_range(0, 1));
      decimal   = 1'($urandom_range(0, 1));
      carry_in  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (done) got_done = 1;
      else begin
        check_eq("hold_result", result, prev_res);
        check_eq("hold_carry", carry_out, prev_c);
        check_eq("hold_zero", zero_out, prev_z);
      end
    end
    start = 1'b0;
    check_eq("latency", cyc, N);
    check_eq("result", result, exp[W-1:0]);
    check_eq("carry_out", carry_out, exp[W]);
    check_eq("zero_out", zero_out, exp[W-1:0] == '0);
    check_eq("ready_done", ready, 1);
    prev_res = exp[W-1:0];
    prev_c   = exp[W];
    prev_z   = (exp[W-1:0] == '0);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1; start = 1'b0; op = OP_ADD; use_carry = 0; decimal = 0;
    carry_in = 0; a = '0; b = '0;
    prev_res = '0; prev_c = 0; prev_z = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ready", ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_result", result, 0);
    check_eq("rst_carry", carry_out, 0);
    check_eq("rst_zero", zero_out, 0);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases
    run_op(OP_ADD, 8'h3F, 8'h01, 0, 0, 1, 0);
    check_eq("add_bin_res", result, 8'h40);
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("hold_after_done", result, 8'h40);
    run_op(OP_ADD, 8'h59, 8'h48, 1, 1, 1, 0);
    check_eq("add_bcd_res", result, 8'h08);
    run_op(OP_SUB, 8'h20, 8'h01, 0, 1, 0, 0);
    check_eq("sub_bcd_res", result, 8'h19);
    run_op(OP_SUB, 8'h00, 8'h01, 0, 1, 0, 0);
    check_eq("sub_bcd_wrap", result, 8'h99);
    run_op(OP_CP, 8'h12, 8'h12, 1, 0, 1, 0);
    check_eq("cp_zero", zero_out, 1);
    run_op(OP_AND, 8'hF0, 8'h0F, 0, 0, 1, 0);
    check_eq("and_carry", carry_out, 1);
    run_op(OP_RRC, 8'h81, 8'h00, 0, 0, 1, 0);
    check_eq("rrc_res", result, 8'hC0);
    // Back-to-back: second start raised in the done cycle of the first.
    run_op(OP_RLC, 8'h81, 8'h00, 0, 0, 0, 1);
    check_eq("rlc_res", result, 8'h02);

    // Reset after the first nibble: back to idle, outputs cleared, no done.
    @(negedge clk);
    op = OP_ADD; a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("midrst_ready", ready, 1);
    check_eq("midrst_result", result, 0);
    check_eq("midrst_carry", carry_out, 0);
    check_eq("midrst_zero", zero_out, 0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    repeat (N + 3) begin
      @(posedge clk); #1;
      if (done) done_seen++;
    end
    check_eq("midrst_no_done", done_seen, 0);
    prev_res = '0; prev_c = 0; prev_z = 0;

    // Randomized operations, some launched back-to-back.
    for (int i = 0; i < 150; i++) begin
      run_op(alu_op'($urandom_range(0, 8)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
